reg_file_sb: RTL and testbench

//   Parametrised multi-read-port register file with sequential zero-init sweep, write-to-read

---
 rtl/reg_file_defs.sv | 12 +
 rtl/rf_scoreboard.sv | 33 +++
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_defs.sv
// Shared definitions for the scoreboarded register file: FSM encodings and default geometry.
package reg_file_defs;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: issue marks a destination busy, writeback retires it.
module rf_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [DEPTH-1:0]  pending
);

  logic [DEPTH-1:0] pendingNext;

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    pendingNext = pending;
    if (clr_en) pendingNext[clr_addr] = 1'b0;
    if (set_en) pendingNext[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (en) begin
      pending <= pendingNext;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with zero-init sweep, write bypass, optional zero R0
// and a scoreboard of pending destinations for decode-stage hazard checks.
module reg_file_sb
  import reg_file_defs::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter bit ZERO_R0   = 1'b1,
  parameter bit WR_BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     wEn,
  input  logic [ADDR_W-1:0]        Rw,
  input  logic [DATA_W-1:0]        busW,
  input  logic [NUM_RD*ADDR_W-1:0] Ra,
  output logic [NUM_RD*DATA_W-1:0] busA,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_rd,
  output rf_state_e                dbgState
);

  if (ADDR_W != $clog2(DEPTH)) begin : gBadAddrW
    $error("reg_file_sb: ADDR_W must equal clog2(DEPTH)");
  end

  rf_state_e         state, stateNext;
  logic [ADDR_W-1:0] cnt, cntNext;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              run;
  logic              wrDrop;
  logic              issDrop;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  // ready is a level status, not a handshake: while low every port input is ignored.
  assign run      = (state == RF_RUN) && !rst;
  assign ready    = run;
  assign dbgState = state;
  assign wrDrop   = ZERO_R0 && (Rw == '0);
  assign issDrop  = ZERO_R0 && (iss_rd == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // The single write port is shared between the init sweep and writeback.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    memWe     = 1'b0;
    memAddr   = Rw;
    memData   = busW;
    unique case (state)
      RF_INIT: begin
        memWe   = 1'b1;
        memAddr = cnt;
        memData = '0;
        cntNext = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) stateNext = RF_RUN;
      end
      RF_RUN: begin
        memWe = wEn && !wrDrop;
      end
      default: stateNext = RF_INIT;
    endcase
    if (rst) memWe = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uScoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .set_en   (iss_en && !issDrop),
    .set_addr (iss_rd),
    .clr_en   (wEn),
    .clr_addr (Rw),
    .pending  (pending)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              isZero;

    assign addr   = Ra[k*ADDR_W +: ADDR_W];
    assign hit    = WR_BYPASS && wEn && (Rw == addr);
    assign isZero = ZERO_R0 && (addr == '0);

    // A forwarded value is by definition no longer pending.
    assign busA[k*DATA_W +: DATA_W] = (!run || isZero) ? '0 : (hit ? busW : mem[addr]);
    assign rd_busy[k] = run && !isZero && !hit && pending[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default configuration plus a 4-port, 64-bit, no-zero, no-bypass variant.
module tb_reg_file_sb;
  import reg_file_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        wEnA;
  logic [4:0]  RwA;
  logic [31:0] busWA;
  logic [9:0]  RaA;
  logic [63:0] busAA;
  logic [1:0]  rdBusyA;
  logic        issEnA;
  logic [4:0]  issRdA;
  logic        readyA;
  rf_state_e   dbgA;

  logic         wEnB;
  logic [3:0]   RwB;
  logic [63:0]  busWB;
  logic [15:0]  RaB;
  logic [255:0] busAB;
  logic [3:0]   rdBusyB;
  logic         issEnB;
  logic [3:0]   issRdB;
  logic         readyB;
  rf_state_e    dbgB;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [31:0] memA [32];
  bit   [31:0] pendA;
  int          leftA;
  logic [63:0] memB [16];
  bit   [15:0] pendB;
  int          leftB;

  reg_file_sb dutA (
    .clk (clk), .rst (rst), .ready (readyA),
    .wEn (wEnA), .Rw (RwA), .busW (busWA),
    .Ra (RaA), .busA (busAA), .rd_busy (rdBusyA),
    .iss_en (issEnA), .iss_rd (issRdA), .dbgState (dbgA)
  );

  reg_file_sb #(
    .DATA_W (64), .DEPTH (16), .ADDR_W (4), .NUM_RD (4),
    .ZERO_R0 (1'b0), .WR_BYPASS (1'b0)
  ) dutB (
    .clk (clk), .rst (rst), .ready (readyB),
    .wEn (wEnB), .Rw (RwB), .busW (busWB),
    .Ra (RaB), .busA (busAB), .rd_busy (rdBusyB),
    .iss_en (issEnB), .iss_rd (issRdB), .dbgState (dbgB)
  );

  // Reference model: a register array, a pending set and an init-cycles-remaining count.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      leftA = 32;
      leftB = 16;
      pendA = '0;
      pendB = '0;
      foreach (memA[i]) memA[i] = '0;
      foreach (memB[i]) memB[i] = '0;
    end else begin
      if (leftA > 0) leftA--;
      else begin
        if (wEnA) begin
          if (RwA != 0) memA[RwA] = busWA;
          pendA[RwA] = 1'b0;
        end
        if (issEnA && issRdA != 0) pendA[issRdA] = 1'b1;
      end
      if (leftB > 0) leftB--;
      else begin
        if (wEnB) begin
          memB[RwB]  = busWB;
          pendB[RwB] = 1'b0;
        end
        if (issEnB) pendB[issRdB] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] expDataA(logic [4:0] a);
    if (rst || leftA != 0 || a == 0) return '0;
    if (wEnA && RwA == a) return busWA;
    return memA[a];
  endfunction

  function automatic logic expBusyA(logic [4:0] a);
    if (rst || leftA != 0 || a == 0) return 1'b0;
    if (wEnA && RwA == a) return 1'b0;
    return pendA[a];
  endfunction

  function automatic logic [63:0] expDataB(logic [3:0] a);
    if (rst || leftB != 0) return '0;
    return memB[a];
  endfunction

  function automatic logic expBusyB(logic [3:0] a);
    if (rst || leftB != 0) return 1'b0;
    return pendB[a];
  endfunction

  task automatic idleInputs();
    wEnA = 0; RwA = 0; busWA = 0; RaA = 0; issEnA = 0; issRdA = 0;
    wEnB = 0; RwB = 0; busWB = 0; RaB = 0; issEnB = 0; issRdB = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    totalCnt++;
    if (readyA !== 1'b0 || busAA !== '0 || rdBusyA !== '0) begin
      $display("FAIL reset_outputs: got ready=%b busA=%h busy=%b exp 0/0/0", readyA, busAA, rdBusyA);
    end else passCnt++;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wEnA   = 1'b1;
      RwA    = (i == 0) ? 5'd0 : 5'($urandom_range(0, i - 1));
      busWA  = $urandom;
      issEnA = 1'b1;
      issRdA = 5'($urandom_range(1, 31));
      RaA    = {RwA, RwA};
      #1;
      totalCnt++;
      if (readyA !== 1'b0 || busAA !== '0) begin
        $display("FAIL init_quiet cycle%0d: got ready=%b busA=%h exp 0/0", i, readyA, busAA);
      end else passCnt++;
      tick();
    end
    idleInputs();
    #1;
    totalCnt++;
    if (readyA !== 1'b1 || dbgA !== RF_RUN) begin
      $display("FAIL ready_after_32: got ready=%b state=%0d exp 1/%0d", readyA, dbgA, RF_RUN);
    end else passCnt++;
    for (int r = 0; r < 32; r += 2) begin
      RaA = {5'(r + 1), 5'(r)};
      #1;
      totalCnt++;
      if (busAA !== '0 || rdBusyA !== '0) begin
        $display("FAIL init_zero r%0d: got busA=%h busy=%b exp 0", r, busAA, rdBusyA);
      end else passCnt++;
      tick();
    end
  endtask

  task automatic test_write_read();
    wEnA = 1'b1; RwA = 5'd5; busWA = 32'hDEADBEEF;
    tick();
    RwA = 5'd7; busWA = 32'h0000_1234; RaA = {5'd7, 5'd5};
    #1;
    totalCnt++;
    if (busAA[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL write_then_read: got %h exp deadbeef", busAA[31:0]);
    end else passCnt++;
    totalCnt++;
    if (busAA[63:32] !== 32'h0000_1234) begin
      $display("FAIL bypass_same_cycle: got %h exp 00001234", busAA[63:32]);
    end else passCnt++;
    tick();
    idleInputs();
  endtask

  task automatic test_zero_reg();
    wEnA = 1'b1; RwA = 5'd0; busWA = 32'hFFFFFFFF;
    issEnA = 1'b1; issRdA = 5'd0; RaA = {5'd0, 5'd0};
    #1;
    totalCnt++;
    if (busAA !== '0 || rdBusyA !== '0) begin
      $display("FAIL r0_same_cycle: got busA=%h busy=%b exp 0/0", busAA, rdBusyA);
    end else passCnt++;
    tick();
    idleInputs();
    #1;
    totalCnt++;
    if (busAA !== '0 || rdBusyA !== '0) begin
      $display("FAIL r0_after: got busA=%h busy=%b exp 0/0", busAA, rdBusyA);
    end else passCnt++;
  endtask

  task automatic test_scoreboard();
    issEnA = 1'b1; issRdA = 5'd9;
    tick();
    issEnA = 1'b0; RaA = {5'd9, 5'd9};
    #1;
    totalCnt++;
    if (rdBusyA !== 2'b11) begin
      $display("FAIL busy_after_issue: got %b exp 11", rdBusyA);
    end else passCnt++;
    wEnA = 1'b1; RwA = 5'd9; busWA = 32'hA5A5_0009;
    #1;
    totalCnt++;
    if (rdBusyA !== 2'b00 || busAA[31:0] !== 32'hA5A5_0009) begin
      $display("FAIL busy_bypass: got busy=%b data=%h exp 00/a5a50009", rdBusyA, busAA[31:0]);
    end else passCnt++;
    tick();
    wEnA = 1'b0;
    #1;
    totalCnt++;
    if (rdBusyA !== 2'b00) begin
      $display("FAIL busy_cleared: got %b exp 00", rdBusyA);
    end else passCnt++;
    issEnA = 1'b1; issRdA = 5'd9; wEnA = 1'b1; RwA = 5'd9; busWA = 32'h0000_0099;
    tick();
    idleInputs();
    RaA = {5'd9, 5'd9};
    #1;
    totalCnt++;
    if (rdBusyA !== 2'b11 || busAA[31:0] !== 32'h0000_0099) begin
      $display("FAIL set_wins: got busy=%b data=%h exp 11/00000099", rdBusyA, busAA[31:0]);
    end else passCnt++;
    wEnA = 1'b1; RwA = 5'd9; issEnA = 1'b1; issRdA = 5'd10; busWA = 32'h1;
    tick();
    idleInputs();
    RaA = {5'd10, 5'd9};
    #1;
    totalCnt++;
    if (rdBusyA !== 2'b10) begin
      $display("FAIL set_clr_distinct: got %b exp 10", rdBusyA);
    end else passCnt++;
  endtask

  task automatic test_random_a(int n);
    logic [4:0] a;
    for (int c = 0; c < n; c++) begin
      wEnA   = 1'($urandom_range(0, 1));
      RwA    = 5'($urandom_range(0, 7));
      busWA  = $urandom;
      issEnA = ($urandom_range(0, 2) == 0);
      issRdA = 5'($urandom_range(0, 7));
      RaA    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < 2; k++) begin
        a = RaA[k*5 +: 5];
        totalCnt++;
        if (busAA[k*32 +: 32] !== expDataA(a) || rdBusyA[k] !== expBusyA(a)) begin
          $display("FAIL rand_a c%0d port%0d addr%0d: got %h/%b exp %h/%b",
                   c, k, a, busAA[k*32 +: 32], rdBusyA[k], expDataA(a), expBusyA(a));
        end else passCnt++;
      end
      tick();
    end
    idleInputs();
  endtask

  task automatic test_rst_mid();
    issEnA = 1'b1; issRdA = 5'd12;
    tick();
    issEnA = 1'b0; RaA = {5'd0, 5'd12};
    #1;
    totalCnt++;
    if (rdBusyA[0] !== 1'b1) begin
      $display("FAIL pending_before_rst: got %b exp 1", rdBusyA[0]);
    end else passCnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    totalCnt++;
    if (dbgA !== RF_INIT || readyA !== 1'b0) begin
      $display("FAIL mid_sweep_state: got state=%0d ready=%b exp %0d/0", dbgA, readyA, RF_INIT);
    end else passCnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      totalCnt++;
      if (readyA !== 1'b0) begin
        $display("FAIL restart_early edge%0d: got ready=%b exp 0", i, readyA);
      end else passCnt++;
    end
    tick();
    #1;
    totalCnt++;
    if (readyA !== 1'b1 || rdBusyA[0] !== 1'b0) begin
      $display("FAIL restart_ready: got ready=%b busy=%b exp 1/0", readyA, rdBusyA[0]);
    end else passCnt++;
  endtask

  task automatic test_cfg_b(int n);
    logic [3:0] a;
    totalCnt++;
    if (readyB !== 1'b1) begin
      $display("FAIL b_ready: got %b exp 1", readyB);
    end else passCnt++;
    wEnB = 1'b1; RwB = 4'd0; busWB = 64'h0123_4567_89AB_CDEF; RaB = {4'd3, 4'd2, 4'd0, 4'd0};
    #1;
    totalCnt++;
    if (busAB[63:0] !== 64'h0 || busAB[127:64] !== 64'h0) begin
      $display("FAIL b_no_bypass: got %h exp 0", busAB[63:0]);
    end else passCnt++;
    tick();
    wEnB = 1'b0;
    #1;
    totalCnt++;
    if (busAB[63:0] !== 64'h0123_4567_89AB_CDEF || busAB[127:64] !== 64'h0123_4567_89AB_CDEF) begin
      $display("FAIL b_r0_writable: got %h exp 0123456789abcdef", busAB[63:0]);
    end else passCnt++;
    issEnB = 1'b1; issRdB = 4'd0;
    tick();
    issEnB = 1'b0;
    #1;
    totalCnt++;
    if (rdBusyB[0] !== 1'b1) begin
      $display("FAIL b_r0_pending: got %b exp 1", rdBusyB[0]);
    end else passCnt++;
    wEnB = 1'b1; RwB = 4'd0; busWB = 64'hFEED_0000_0000_0001;
    #1;
    totalCnt++;
    if (rdBusyB[0] !== 1'b1 || busAB[63:0] !== 64'h0123_4567_89AB_CDEF) begin
      $display("FAIL b_old_value: got busy=%b data=%h exp 1/0123456789abcdef", rdBusyB[0], busAB[63:0]);
    end else passCnt++;
    tick();
    idleInputs();
    #1;
    totalCnt++;
    if (rdBusyB[0] !== 1'b0 || busAB[63:0] !== 64'hFEED_0000_0000_0001) begin
      $display("FAIL b_after_write: got busy=%b data=%h exp 0/feed000000000001", rdBusyB[0], busAB[63:0]);
    end else passCnt++;
    for (int c = 0; c < n; c++) begin
      wEnB   = 1'($urandom_range(0, 1));
      RwB    = 4'($urandom_range(0, 5));
      busWB  = {$urandom, $urandom};
      issEnB = ($urandom_range(0, 2) == 0);
      issRdB = 4'($urandom_range(0, 5));
      for (int k = 0; k < 4; k++) RaB[k*4 +: 4] = 4'($urandom_range(0, 5));
      #1;
      for (int k = 0; k < 4; k++) begin
        a = RaB[k*4 +: 4];
        totalCnt++;
        if (busAB[k*64 +: 64] !== expDataB(a) || rdBusyB[k] !== expBusyB(a)) begin
          $display("FAIL rand_b c%0d port%0d addr%0d: got %h/%b exp %h/%b",
                   c, k, a, busAB[k*64 +: 64], rdBusyB[k], expDataB(a), expBusyB(a));
        end else passCnt++;
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_random_a(200);
    test_rst_mid();
    test_random_a(100);
    test_cfg_b(150);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
